// File: rtl/literal_parser_if.sv
// Character-stream input and parsed-result output handshakes for literal_parser.
interface literal_parser_if;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned WIDTH_W = 6;
  localparam int unsigned VALUE_W = 32;

  logic               in_valid;
  logic [CHAR_W-1:0]  in_char;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_W-1:0] out_width;
  logic [VALUE_W-1:0] out_value;
  logic               out_error;

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_width, out_value, out_error
  );

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_width, out_value, out_error
  );
endinterface

// File: rtl/literal_parser.sv
// Parses sized Verilog-style literals (<width>'<b|h|d><digits><terminator>) from a char stream.
// Define LITERAL_PARSER_UNDERSCORE_EN to accept '_' as a digit separator.
module literal_parser #(
  parameter int unsigned MAX_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  literal_parser_if.slave bus
);
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned WIDTH_W = 6;
  localparam int unsigned VALUE_W = 32;
  localparam int unsigned ACC_W   = 64;
  localparam int unsigned WSUM_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_WIDTH, S_BASE, S_DIGITS, S_SKIP, S_EMIT
  } state_e;

  typedef enum logic [1:0] {BASE_BIN, BASE_DEC, BASE_HEX} base_e;

  state_e               state_q, state_d;
  base_e                base_q, base_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 has_dig_q, has_dig_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH_W-1:0]   out_width_q, out_width_d;
  logic [VALUE_W-1:0]   out_value_q, out_value_d;
  logic                 out_error_q, out_error_d;

  function automatic logic is_term(input logic [CHAR_W-1:0] c);
    return (c == 8'h20) || (c == 8'h3B) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h2C);
  endfunction

  function automatic logic is_dec(input logic [CHAR_W-1:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Returns {valid, value} for c interpreted as a digit in base b.
  function automatic logic [4:0] digit_of(input logic [CHAR_W-1:0] c, input base_e b);
    logic [4:0] r;
    r = 5'd0;
    if (is_dec(c)) begin
      r = {1'b1, 4'(c - 8'h30)};
      if (b == BASE_BIN && c > 8'h31) r = 5'd0;
    end else if (b == BASE_HEX && c >= 8'h61 && c <= 8'h66) begin
      r = {1'b1, 4'(c - 8'h57)};
    end else if (b == BASE_HEX && c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, 4'(c - 8'h37)};
    end
    return r;
  endfunction

  logic                xfer;
  logic [CHAR_W-1:0]   ch;
  logic [4:0]          dig;
  logic [WSUM_W-1:0]   wsum;
  logic [ACC_W-1:0]    mult;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    limit;
  logic                width_bad;
  logic                emit;
  logic                emit_err;

  assign xfer      = bus.in_valid && in_ready_q;
  assign ch        = bus.in_char;
  assign dig       = digit_of(ch, base_q);
  assign wsum      = WSUM_W'(width_q) * WSUM_W'(10) + WSUM_W'(ch[3:0]);
  assign mult      = (base_q == BASE_BIN) ? ACC_W'(2) : (base_q == BASE_HEX) ? ACC_W'(16) : ACC_W'(10);
  assign acc       = ACC_W'(value_q) * mult + ACC_W'(dig[3:0]);
  assign limit     = (ACC_W'(1) << width_q) - ACC_W'(1);
  assign width_bad = (width_q == WIDTH_W'(0)) || (32'(width_q) > MAX_W);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    width_d     = width_q;
    value_d     = value_q;
    ovf_d       = ovf_q;
    has_dig_d   = has_dig_q;
    out_width_d = out_width_q;
    out_value_d = out_value_q;
    out_error_d = out_error_q;
    emit        = 1'b0;
    emit_err    = 1'b0;

    unique case (state_q)
      S_IDLE: if (xfer) begin
        if (is_dec(ch)) begin
          state_d   = S_WIDTH;
          width_d   = WIDTH_W'(ch[3:0]);
          value_d   = '0;
          ovf_d     = 1'b0;
          has_dig_d = 1'b0;
        end else if (!is_term(ch)) begin
          state_d = S_SKIP;
        end
      end
      S_WIDTH: if (xfer) begin
        if (is_dec(ch)) begin
          width_d = (wsum > WSUM_W'(63)) ? WIDTH_W'(63) : WIDTH_W'(wsum);
        end else if (ch == 8'h27) begin
          state_d = S_BASE;
        end else if (is_term(ch)) begin
          emit     = 1'b1;
          emit_err = 1'b1;
        end else begin
          state_d = S_SKIP;
        end
      end
      S_BASE: if (xfer) begin
        state_d = S_DIGITS;
        if (ch == 8'h62 || ch == 8'h42)      base_d = BASE_BIN;
        else if (ch == 8'h68 || ch == 8'h48) base_d = BASE_HEX;
        else if (ch == 8'h64 || ch == 8'h44) base_d = BASE_DEC;
        else                                 state_d = S_SKIP;
      end
      S_DIGITS: if (xfer) begin
        if (dig[4]) begin
          value_d   = VALUE_W'(acc);
          has_dig_d = 1'b1;
          if (acc > limit) ovf_d = 1'b1;
`ifdef LITERAL_PARSER_UNDERSCORE_EN
        end else if (ch == 8'h5F) begin
          state_d = S_DIGITS;
`endif
        end else if (is_term(ch)) begin
          emit     = 1'b1;
          emit_err = ovf_q || !has_dig_q || width_bad;
        end else begin
          state_d = S_SKIP;
        end
      end
      S_SKIP: if (xfer && is_term(ch)) begin
        emit     = 1'b1;
        emit_err = 1'b1;
      end
      S_EMIT: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result is latched once on entry to EMIT and held until accepted.
    if (emit) begin
      state_d     = S_EMIT;
      out_width_d = emit_err ? '0 : width_q;
      out_value_d = emit_err ? '0 : value_q;
      out_error_d = emit_err;
    end

    out_valid_d = (state_d == S_EMIT);
    in_ready_d  = (state_d != S_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= BASE_BIN;
      width_q     <= '0;
      value_q     <= '0;
      ovf_q       <= 1'b0;
      has_dig_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_width_q <= '0;
      out_value_q <= '0;
      out_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      width_q     <= width_d;
      value_q     <= value_d;
      ovf_q       <= ovf_d;
      has_dig_q   <= has_dig_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_width_q <= out_width_d;
      out_value_q <= out_value_d;
      out_error_q <= out_error_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_width = out_width_q;
  assign bus.out_value = out_value_q;
  assign bus.out_error = out_error_q;
endmodule

// File: tb/tb_literal_parser.sv
// Directed, table-driven bench for literal_parser plus backpressure and reset sequences.
module tb_literal_parser;
  logic clk;
  logic rst_n;
  literal_parser_if bus();

  literal_parser #(.MAX_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       stim;
    logic [5:0]  w;
    logic [31:0] v;
    logic        e;
  } vec_t;

  typedef struct {
    logic [5:0]  w;
    logic [31:0] v;
    logic        e;
    int          cyc;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   xfer_cyc = 0;
  res_t resq[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every accepted result with the cycle it was first visible in.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      resq.push_back('{bus.out_width, bus.out_value, bus.out_error, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      xfer_cyc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic expect_result(input string name, input logic [5:0] w, input logic [31:0] v, input logic e);
    int n;
    res_t r;
    n = 0;
    while (resq.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (resq.size() == 0) begin
      chk({name, "_no_result"}, 32'd0, 32'd1);
    end else begin
      r = resq.pop_front();
      chk({name, "_width"}, 32'(r.w), 32'(w));
      chk({name, "_value"}, r.v, v);
      chk({name, "_error"}, 32'(r.e), 32'(e));
      chk({name, "_latency"}, 32'(r.cyc), 32'(xfer_cyc));
    end
  endtask

  initial begin
    vecs.push_back('{"3'b000;",        6'd3,  32'd0,        1'b0});
    vecs.push_back('{"4'hc ",          6'd4,  32'd12,       1'b0});
    vecs.push_back('{"5'd13\n",        6'd5,  32'd13,       1'b0});
`ifdef LITERAL_PARSER_UNDERSCORE_EN
    vecs.push_back('{"8'b0001_0111;",  6'd8,  32'h17,       1'b0});
`else
    vecs.push_back('{"8'b0001_0111;",  6'd0,  32'd0,        1'b1});
`endif
    vecs.push_back('{"3'd9;",          6'd0,  32'd0,        1'b1});
    vecs.push_back('{"0'b0;",          6'd0,  32'd0,        1'b1});
    vecs.push_back('{"40'h1;",         6'd0,  32'd0,        1'b1});
    vecs.push_back('{"4'x5;",          6'd0,  32'd0,        1'b1});
    vecs.push_back('{"4'h;",           6'd0,  32'd0,        1'b1});
    vecs.push_back('{"32'hFFFFFFFF;",  6'd32, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"8'd255,",        6'd8,  32'd255,      1'b0});
    vecs.push_back('{"8'd256;",        6'd0,  32'd0,        1'b1});
    vecs.push_back('{"12'hAbC\r",      6'd12, 32'hABC,      1'b0});
    vecs.push_back('{"5;",             6'd0,  32'd0,        1'b1});
    vecs.push_back('{" ;\n2'b10;",     6'd2,  32'd2,        1'b0});
    vecs.push_back('{"x1;",            6'd0,  32'd0,        1'b1});
    vecs.push_back('{"8'b12;",         6'd0,  32'd0,        1'b1});
    vecs.push_back('{"2'B11 ",         6'd2,  32'd3,        1'b0});

    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_width", 32'(bus.out_width), 32'd0);
    chk("rst_out_value", bus.out_value,      32'd0);
    chk("rst_out_error", 32'(bus.out_error), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      send_str(vecs[i].stim);
      expect_result($sformatf("vec%0d", i), vecs[i].w, vecs[i].v, vecs[i].e);
    end

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    send_str("4'hc;");
    for (int n = 0; n < 20 && bus.out_valid !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_width",     32'(bus.out_width), 32'd4);
      chk("bp_value",     bus.out_value,      32'd12);
      chk("bp_error",     32'(bus.out_error), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_one_result", 32'(resq.size()), 32'd1);
    resq.delete();

    // Reset mid-literal discards the partial value.
    send_str("16'hA");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_str("2'b11;");
    expect_result("after_rst", 6'd2, 32'd3, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("no_extra_results", 32'(resq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/literal_parser.md
LITERAL_PARSER -- requirements
Module: literal_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: MAX_W, default 32, maximum literal width accepted in bits (range 1..32).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  in_char holds a character this cycle.
REQ-006 Port: in_char  input  8  ASCII character of the literal text stream.
REQ-007 Port: in_ready  output  1  parser accepts in_char this cycle.
REQ-008 Port: out_valid  output  1  a parsed literal result is presented.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out_width  output  6  declared width of the literal (0 on error).
REQ-011 Port: out_value  output  32  literal value, zero-extended above out_width (0 on error).
REQ-012 Port: out_error  output  1  literal was malformed or its value overflowed.

Function
REQ-013 The parser SHALL decode sized literals of the form <width>'<base><digits>, followed by a terminator (space, ';', LF, CR, or ',').
- A character transfers when in_valid and in_ready are both 1.
REQ-014 FSM states SHALL be:
- IDLE: skip terminators; a decimal digit starts the width and goes to WIDTH; any other character goes to SKIP.
- WIDTH: decimal digits accumulate the width, saturating at 63; a ''' character goes to BASE; any other character goes to SKIP, or, if it is a terminator, to EMIT with an error.
- BASE: b/B, h/H or d/D selects the base and goes to DIGITS; anything else goes to SKIP.
- DIGITS: see REQ-016.
- SKIP: discard characters until a terminator, then go to EMIT with out_error=1.
- EMIT: present the result.
REQ-015 Accumulation SHALL be value = value*2 + d (binary), value*16 + d (hex, 0-9/a-f/A-F) or value*10 + d (decimal).
- The running value SHALL be compared against 2^width-1 on every digit.
- Exceeding 2^width-1 SHALL set a sticky overflow flag, and the literal SHALL be reported as an error.
REQ-016 In DIGITS:
- A digit that is invalid for the selected base goes to SKIP.
- A terminator goes to EMIT.
REQ-017 A width of 0 or greater than MAX_W SHALL produce out_error=1.
REQ-018 A literal with an empty digit field (for example "4'h;") SHALL produce out_error=1.
REQ-019 Outputs in EMIT SHALL be out_valid=1 and out_width = declared width; out_value = value with out_error=0, or out_width=0, out_value=0 and out_error=1.
REQ-020 Latency: out_valid SHALL rise in the cycle after the terminator is accepted.
REQ-021 in_ready SHALL be 1 in every state except EMIT, where it SHALL be 0.
REQ-022 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid and out_ready both 1, the FSM SHALL return to IDLE, with out_valid=0 and in_ready=1 in the next cycle.
REQ-024 A terminator arriving in IDLE SHALL be consumed with no result emitted.
REQ-025 A stream that ends mid-literal SHALL leave the FSM waiting, with no timeout.

Reset
REQ-026 When rst_n=0, state SHALL be IDLE and the outputs SHALL be in_ready=0, out_valid=0, out_width=0, out_value=0, out_error=0.
REQ-027 Asserting reset mid-literal SHALL discard the partial literal.
- The first literal after reset SHALL parse cleanly.
REQ-028 in_ready SHALL become 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 With macro LITERAL_PARSER_UNDERSCORE_EN defined, '_' in DIGITS SHALL be accepted and ignored as a digit separator; it SHALL NOT count as a digit for REQ-018.
REQ-030 Without LITERAL_PARSER_UNDERSCORE_EN, '_' in DIGITS SHALL go to SKIP, so the literal produces out_error=1.

Verification
REQ-031 Stream "3'b000;" with out_ready=1 -> width=3, value=0, error=0, valid one cycle after ';'.
REQ-032 Stream "4'hc 5'd13\n" -> (width=4, value=12, error=0) then (width=5, value=13, error=0).
REQ-033 Stream "8'b0001_0111;" -> with the macro: width=8, value=0x17, error=0; without it: width=0, value=0, error=1.
REQ-034 Streams "3'd9;", "0'b0;", "40'h1;", "4'x5;" and "4'h;" -> each produces width=0, value=0, error=1.
REQ-035 After "4'hc;", hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable throughout; out_ready=1 -> valid drops and in_ready=1 in the next cycle.
REQ-036 Drive rst_n=0 after "16'hA" has been accepted, release, then send "2'b11;" -> width=2, value=3, error=0.
